// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_ADDR_STEP = 4;

  // True when the byte index selects the most significant lane of a word.
  function automatic logic is_last_lane(input logic [1:0] index);
    return index == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Little-endian byte-to-word assembler: byte k of a word lands in lane [8k+7:8k].
module word_assembler
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load_byte,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] index;

  // The byte being loaded now completes the word.
  assign word_full = load_byte && is_last_lane(index);

  // Byte index counter and lane register; the index wraps after the last lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
      word  <= '0;
    end else if (clear) begin
      index <= '0;
      word  <= '0;
    end else if (load_byte) begin
      case (index)
        2'd0:    word[7:0]   <= data;
        2'd1:    word[15:8]  <= data;
        2'd2:    word[23:16] <= data;
        default: word[31:24] <= data;
      endcase
      index <= index + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: byte stream in, one word write per four bytes.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int size_memory  = 1024,
  parameter int size_address = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [size_address-1:0] wr_address,
  output logic [31:0]             wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [size_address-2:0] words_loaded
);

  localparam logic [size_address-2:0] MAX_WORDS = (size_address-1)'(size_memory);
  localparam logic [size_address-1:0] ADDR_STEP = size_address'(WORD_ADDR_STEP);

  loader_state_t state, state_next;

  logic [size_address-1:0] addr_q;
  logic                    last_q;
  logic                    accept;
  logic                    at_capacity;
  logic                    load_byte;
  logic                    clear;
  logic                    word_full;

  // A byte is accepted whenever the source offers one in RECEIVE.
  assign accept      = in_valid && (state == RECEIVE);
  assign at_capacity = (words_loaded == MAX_WORDS);
  // Bytes arriving once the memory is full are dropped rather than assembled.
  assign load_byte   = accept && !at_capacity;
  assign clear       = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  word_assembler u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load_byte (load_byte),
    .data      (in_data),
    .word      (wr_data),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; overflow takes precedence over word completion and in_last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = RECEIVE;
        end
      end
      RECEIVE: begin
        if (accept) begin
          if (at_capacity) begin
            state_next = ERROR;
          end else if (word_full) begin
            state_next = WRITE;
          end else if (in_last) begin
            state_next = ERROR;
          end
        end
      end
      WRITE: begin
        state_next = last_q ? DONE : RECEIVE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address and word counters; the write address is latched with the completing
  // byte so it keeps naming the last written word once the counter moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      words_loaded <= '0;
      wr_address   <= '0;
      last_q       <= 1'b0;
    end else begin
      if (clear) begin
        addr_q       <= '0;
        words_loaded <= '0;
      end
      if (word_full) begin
        wr_address <= addr_q;
        last_q     <= in_last;
      end
      if (state == WRITE) begin
        addr_q       <= addr_q + ADDR_STEP;
        words_loaded <= words_loaded + (size_address-1)'(1);
      end
    end
  end

  // Status and handshake outputs decoded from state only.
  assign in_ready = (state == RECEIVE);
  assign wr_en    = (state == WRITE);
  assign busy     = (state == RECEIVE) || (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

endmodule
